// File: rtl/snow64_instr_cache_pkg.sv
// snow64_instr_cache_pkg: shared widths, address-field positions, FSM states and port structs.
package PkgSnow64InstrCache;
  localparam int NUM_LINES = 64;
  localparam int WIDTH__LINE = 256;
  localparam int WIDTH__ADDR = 64;
  localparam int WIDTH__INSTR = 32;
  localparam int WIDTH__WORD = $clog2(WIDTH__LINE / WIDTH__INSTR);
  localparam int LSB__WORD = 2;
  localparam int MSB__WORD = LSB__WORD + WIDTH__WORD - 1;
  localparam int WIDTH__INDEX = $clog2(NUM_LINES);
  localparam int LSB__INDEX = MSB__WORD + 1;
  localparam int MSB__INDEX = LSB__INDEX + WIDTH__INDEX - 1;
  localparam int LSB__TAG = MSB__INDEX + 1;
  localparam int MSB__TAG = WIDTH__ADDR - 1;
  localparam int WIDTH__TAG = MSB__TAG - LSB__TAG + 1;

  typedef logic [WIDTH__ADDR-1:0] addr_t;
  typedef logic [WIDTH__LINE-1:0] line_t;
  typedef logic [WIDTH__INSTR-1:0] instr_t;
  typedef logic [WIDTH__WORD-1:0] word_t;
  typedef logic [WIDTH__INDEX-1:0] index_t;
  typedef logic [WIDTH__TAG-1:0] tag_t;

  typedef enum logic [1:0] {StIdle, StMissWait, StFillDone} state_t;

  typedef struct packed {
    logic req;
    addr_t addr;
    logic flush;
  } PortIn_Snow64InstrCache_FromPipeStageIfId;

  typedef struct packed {
    logic valid;
    instr_t instr;
  } PortOut_Snow64InstrCache_ToPipeStageIfId;

  typedef struct packed {
    logic valid;
    line_t data;
  } PortIn_Snow64InstrCache_FromMemArbiter;

  typedef struct packed {
    logic req;
    addr_t addr;
  } PortOut_Snow64InstrCache_ToMemArbiter;

  function automatic instr_t get_instr(input line_t l, input word_t w);
    return l[w*WIDTH__INSTR +: WIDTH__INSTR];
  endfunction
endpackage

// File: rtl/snow64_instr_cache_if.sv
// snow64_instr_cache_if: fetch-side and memory-arbiter-side signals of the instruction cache.
interface snow64_instr_cache_if;
  logic in_req;
  logic [63:0] in_addr;
  logic in_flush;
  logic out_valid;
  logic [31:0] out_instr;
  logic out_mem_req;
  logic [63:0] out_mem_addr;
  logic in_mem_valid;
  logic [255:0] in_mem_data;
  modport master (
    output in_req, in_addr, in_flush, in_mem_valid, in_mem_data,
    input out_valid, out_instr, out_mem_req, out_mem_addr
  );
  modport slave (
    input in_req, in_addr, in_flush, in_mem_valid, in_mem_data,
    output out_valid, out_instr, out_mem_req, out_mem_addr
  );
endinterface

// File: rtl/snow64_instr_cache_line_ram.sv
// snow64_instr_cache_line_ram: valid/tag/data line store with one read port, one write port and flush-all.
module snow64_instr_cache_line_ram
  import PkgSnow64InstrCache::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  index_t rd_index,
  output logic   rd_valid,
  output tag_t   rd_tag,
  output line_t  rd_data,
  input  logic   we,
  input  index_t wr_index,
  input  logic   wr_valid,
  input  tag_t   wr_tag,
  input  line_t  wr_data
);
  logic [NUM_LINES-1:0] valid_q, valid_d;
  tag_t tag_q [NUM_LINES];
  line_t data_q [NUM_LINES];
  // flush wins over a same-edge fill so a flushed line never reappears valid
  always_comb begin
    valid_d = valid_q;
    if (we) valid_d[wr_index] = wr_valid;
    if (flush) valid_d = '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) valid_q <= '0;
    else valid_q <= valid_d;
  always_ff @(posedge clk)
    if (we) begin
      tag_q[wr_index] <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  assign rd_valid = valid_q[rd_index];
  assign rd_tag = tag_q[rd_index];
  assign rd_data = data_q[rd_index];
endmodule

// File: rtl/snow64_instr_cache.sv
// snow64_instr_cache: direct-mapped read-only instruction cache with single-line miss fill.
module snow64_instr_cache
  import PkgSnow64InstrCache::*;
(
  input logic clk,
  input logic rst,
  snow64_instr_cache_if.slave bus
);
  PortIn_Snow64InstrCache_FromPipeStageIfId pipe_in;
  PortIn_Snow64InstrCache_FromMemArbiter mem_in;
  PortOut_Snow64InstrCache_ToPipeStageIfId pipe_q, pipe_d;
  PortOut_Snow64InstrCache_ToMemArbiter mem_q, mem_d;
  state_t state_q, state_d;
  word_t word_q, word_d;
  logic flushed_q, flushed_d;
  logic rd_valid, hit, we;
  tag_t rd_tag;
  line_t rd_data;
  logic unused;
  assign pipe_in = '{req: bus.in_req, addr: bus.in_addr, flush: bus.in_flush};
  assign mem_in = '{valid: bus.in_mem_valid, data: bus.in_mem_data};
  assign unused = &{1'b0, pipe_in.addr[1:0], mem_q.addr[MSB__WORD:0]};
  snow64_instr_cache_line_ram u_ram (
    .clk(clk),
    .rst(rst),
    .flush(pipe_in.flush),
    .rd_index(pipe_in.addr[MSB__INDEX:LSB__INDEX]),
    .rd_valid(rd_valid),
    .rd_tag(rd_tag),
    .rd_data(rd_data),
    .we(we),
    .wr_index(mem_q.addr[MSB__INDEX:LSB__INDEX]),
    .wr_valid(~flushed_q),
    .wr_tag(mem_q.addr[MSB__TAG:LSB__TAG]),
    .wr_data(mem_in.data)
  );
  assign hit = rd_valid && rd_tag == pipe_in.addr[MSB__TAG:LSB__TAG] && !pipe_in.flush;
  // flushed_q remembers a flush seen while the fill was outstanding
  always_comb begin
    state_d = state_q;
    pipe_d = '0;
    mem_d = mem_q;
    word_d = word_q;
    flushed_d = flushed_q | pipe_in.flush;
    we = 1'b0;
    if (state_q == StMissWait) begin
      if (mem_in.valid) begin
        we = 1'b1;
        pipe_d = '{valid: 1'b1, instr: get_instr(mem_in.data, word_q)};
        mem_d = '0;
        state_d = StFillDone;
      end
    end else begin
      state_d = StIdle;
      flushed_d = 1'b0;
      if (pipe_in.req && hit) begin
        pipe_d = '{valid: 1'b1, instr: get_instr(rd_data, pipe_in.addr[MSB__WORD:LSB__WORD])};
      end else if (pipe_in.req) begin
        mem_d = '{req: 1'b1, addr: {pipe_in.addr[MSB__TAG:LSB__INDEX], {LSB__INDEX{1'b0}}}};
        word_d = pipe_in.addr[MSB__WORD:LSB__WORD];
        state_d = StMissWait;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= StIdle;
      pipe_q <= '0;
      mem_q <= '0;
      word_q <= '0;
      flushed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pipe_q <= pipe_d;
      mem_q <= mem_d;
      word_q <= word_d;
      flushed_q <= flushed_d;
    end
  assign bus.out_valid = pipe_q.valid;
  assign bus.out_instr = pipe_q.instr;
  assign bus.out_mem_req = mem_q.req;
  assign bus.out_mem_addr = mem_q.addr;
endmodule

// File: tb/tb_snow64_instr_cache.sv
// tb_snow64_instr_cache: directed stimulus with a response scoreboard checked by a negedge monitor.
module tb_snow64_instr_cache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q [$];

  snow64_instr_cache_if b ();
  snow64_instr_cache dut (.clk(clk), .rst(rst), .bus(b));

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return (32'(a[4:2]) + 32'd1) * 32'h11 + {a[28:5], 8'h00};
  endfunction

  function automatic logic [255:0] line_of(input logic [63:0] la);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = word_of(la + 64'(4 * k));
    return l;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [63:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    b.in_req = 1'b1;
    b.in_addr = a;
    step();
    b.in_req = 1'b0;
  endtask

  task automatic fill(input logic [63:0] la);
    int i;
    i = 0;
    while (!b.out_mem_req && i < 20) begin
      step();
      i++;
    end
    check("mem_req_up", 64'(b.out_mem_req), 64'd1);
    if (!b.out_mem_req) return;
    repeat (3) begin
      step();
      check("mem_addr_stable", b.out_mem_addr, la);
    end
    b.in_mem_valid = 1'b1;
    b.in_mem_data = line_of(la);
    step();
    b.in_mem_valid = 1'b0;
    b.in_mem_data = '0;
    check("mem_req_drop", 64'(b.out_mem_req), 64'd0);
  endtask

  task automatic miss(input logic [63:0] a);
    issue(a, word_of(a));
    check("miss_req", 64'(b.out_mem_req), 64'd1);
    check("miss_addr", b.out_mem_addr, {a[63:5], 5'b0});
    check("miss_valid", 64'(b.out_valid), 64'd0);
    fill({a[63:5], 5'b0});
  endtask

  task automatic hit(input logic [63:0] a, input logic [31:0] e);
    issue(a, e);
    check("hit_no_mem_req", 64'(b.out_mem_req), 64'd0);
  endtask

  always @(negedge clk) begin
    if (b.out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_response: got %0h expected none at %0t", b.out_instr, $time);
      end else check("response", 64'(b.out_instr), 64'(exp_q.pop_front()));
    end else check("invalid_instr_zero", 64'(b.out_instr), 64'd0);
  end

  initial begin
    b.in_req = 1'b0;
    b.in_addr = '0;
    b.in_flush = 1'b0;
    b.in_mem_valid = 1'b0;
    b.in_mem_data = '0;
    repeat (3) step();
    check("rst_valid", 64'(b.out_valid), 64'd0);
    check("rst_instr", 64'(b.out_instr), 64'd0);
    check("rst_mem_req", 64'(b.out_mem_req), 64'd0);
    check("rst_mem_addr", b.out_mem_addr, 64'd0);
    rst = 1'b0;
    step();
    miss(64'h0);
    for (int k = 1; k < 8; k++) hit(64'(4 * k), 32'((k + 1) * 32'h11));
    step();
    miss(64'h800);
    miss(64'h0);
    step();
    issue(64'h20, word_of(64'h20));
    check("flush_miss_req", 64'(b.out_mem_req), 64'd1);
    b.in_flush = 1'b1;
    step();
    b.in_flush = 1'b0;
    fill(64'h20);
    step();
    miss(64'h24);
    step();
    issue(64'h40, word_of(64'h40));
    check("busy_miss_req", 64'(b.out_mem_req), 64'd1);
    b.in_req = 1'b1;
    b.in_addr = 64'h60;
    step();
    b.in_req = 1'b0;
    check("busy_drop_addr", b.out_mem_addr, 64'h40);
    fill(64'h40);
    hit(64'h43, word_of(64'h40));
    step();
    miss(64'h60);
    step();
    b.in_req = 1'b1;
    b.in_addr = 64'h80;
    step();
    b.in_req = 1'b0;
    check("rst_mid_req_up", 64'(b.out_mem_req), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_req_drop", 64'(b.out_mem_req), 64'd0);
    check("rst_mid_valid", 64'(b.out_valid), 64'd0);
    step();
    rst = 1'b0;
    b.in_mem_valid = 1'b1;
    b.in_mem_data = line_of(64'h80);
    step();
    b.in_mem_valid = 1'b0;
    b.in_mem_data = '0;
    check("stray_fill_valid", 64'(b.out_valid), 64'd0);
    check("stray_fill_mem_req", 64'(b.out_mem_req), 64'd0);
    miss(64'h43);
    step();
    miss(64'h80);
    repeat (3) step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
